// File: rtl/pc_unit_if.sv
// Fetch-PC control bundle: redirect requests from ID/EX/exception logic in, PC state out.
// The master drives the redirects; the slave (pc_unit) drives the PC and RAS status.
interface pc_unit_if #(
  parameter int PC_WIDTH = 6
);
  logic                pc_write;
  logic                br_taken;
  logic [PC_WIDTH-1:0] br_target;
  logic                jump;
  logic                call;
  logic [PC_WIDTH-1:0] jump_target;
  logic                ret;
  logic                exc_req;
  logic                eret;
  logic [PC_WIDTH-1:0] pc_out;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] epc_out;
  logic                in_exc;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_err;

  modport master (
    output pc_write, br_taken, br_target, jump, call, jump_target, ret, exc_req, eret,
    input  pc_out, pc_next, epc_out, in_exc, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  pc_write, br_taken, br_target, jump, call, jump_target, ret, exc_req, eret,
    output pc_out, pc_next, epc_out, in_exc, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC with branch/jump/call/return, return-address stack and exception entry/return.
// Redirects take effect one edge after sampling; pc_write=0 holds all state unless an exception is accepted.
module pc_unit #(
  parameter int                  PC_WIDTH     = 6,
  parameter int                  RAS_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = 6'h3C
) (
  input  logic   clk,
  input  logic   rst,
  pc_unit_if.slave bus
);

  localparam int                 PTR_W   = $clog2(RAS_DEPTH);
  localparam int                 CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic {NORMAL, IN_EXC} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  logic [PTR_W-1:0]    top_q, top_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ras_err_q, ras_err_d;
  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic                ras_empty;
  logic                ras_full;
  logic                exc_acc;
  logic                eret_acc;

  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);
  assign exc_acc   = bus.exc_req && (state_q == NORMAL);
  assign eret_acc  = bus.eret && (state_q == IN_EXC);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ras_d     = ras_q;
    ras_err_d = 1'b0;
    if (exc_acc) begin
      pc_d    = EXC_VECTOR;
      epc_d   = pc_q;
      state_d = IN_EXC;
    end else if (bus.pc_write) begin
      if (eret_acc) begin
        pc_d    = epc_q;
        state_d = NORMAL;
      end else if (bus.ret) begin
        // Underflow falls through to the sequential PC rather than a stale entry.
        if (ras_empty) begin
          pc_d      = pc_inc;
          ras_err_d = 1'b1;
        end else begin
          pc_d  = ras_q[top_q];
          top_d = top_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (bus.call) begin
        pc_d                        = bus.jump_target;
        top_d                       = top_q + PTR_W'(1);
        ras_d[top_q + PTR_W'(1)]    = pc_inc;
        // When full, top+1 is the oldest slot, so the push overwrites it in place.
        if (ras_full) ras_err_d = 1'b1;
        else          cnt_d     = cnt_q + CNT_W'(1);
      end else if (bus.jump) begin
        pc_d = bus.jump_target;
      end else if (bus.br_taken) begin
        pc_d = bus.br_target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= NORMAL;
      pc_q      <= RESET_VECTOR;
      epc_q     <= '0;
      top_q     <= '0;
      cnt_q     <= '0;
      ras_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      top_q     <= top_d;
      cnt_q     <= cnt_d;
      ras_err_q <= ras_err_d;
    end
  end

  // Entries beyond the count are never read, so the storage needs no reset.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.pc_out    = pc_q;
  assign bus.pc_next   = pc_d;
  assign bus.epc_out   = epc_q;
  assign bus.in_exc    = (state_q == IN_EXC);
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_err   = ras_err_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined MIPS core: holds the fetch PC and selects the next PC from sequential increment, branch, jump, call/return (via a small return-address stack) and exception entry/return. Sits at the head of the IF stage, driven by the hazard unit (stall) and by the ID/EX/exception logic (redirects). Adds exception vectoring, an EPC register and a return-address stack.

## Interface
- PC_WIDTH, 6, PC width in bits; PC is word-addressed, increment is +1
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_VECTOR, 0, PC value after reset
- EXC_VECTOR, 6'h3C, PC loaded on exception entry

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_write  in  1  1 = PC may update; 0 = stall/bubble, hold PC (exceptions override)
- br_taken  in  1  take conditional branch to br_target
- br_target  in  PC_WIDTH  branch target
- jump  in  1  unconditional jump to jump_target
- call  in  1  jump to jump_target and push pc_out+1 onto RAS
- jump_target  in  PC_WIDTH  jump/call target
- ret  in  1  pop RAS, go to popped address
- exc_req  in  1  exception request for instruction at pc_out
- eret  in  1  return from exception to EPC
- pc_out  out  PC_WIDTH  registered current PC
- pc_next  out  PC_WIDTH  combinational value pc_out will take at next edge
- epc_out  out  PC_WIDTH  exception PC register
- in_exc  out  1  1 while inside exception handler
- ras_empty  out  1  RAS count = 0
- ras_full  out  1  RAS count = RAS_DEPTH
- ras_err  out  1  one-cycle pulse (registered) on RAS underflow pop or overflow push

## Operation
- Next-PC priority, highest first: rst; exc_req (only when in_exc=0); then, only if pc_write=1: eret (only when in_exc=1); ret; call; jump; br_taken; pc_out+1. pc_write=0 with no accepted exception: hold PC and all state.
- Exception entry: pc_out ← EXC_VECTOR, epc_out ← pc_out, in_exc ← 1. Taken even when pc_write=0. exc_req while in_exc=1 ignored (no nesting); selection falls to lower priorities.
- eret: pc_out ← epc_out, in_exc ← 0. eret while in_exc=0 ignored, falls through.
- States: NORMAL (in_exc=0) → IN_EXC on accepted exc_req; IN_EXC → NORMAL on accepted eret. Reset → NORMAL.
- RAS: circular buffer with top pointer and count (0..RAS_DEPTH).
  - call: push pc_out+1. If full: overwrite oldest entry, count stays RAS_DEPTH, ras_err pulses.
  - ret: pop top. If empty: pc_out ← pc_out+1, count stays 0, ras_err pulses.
  - call and ret same cycle: ret wins, no push.
  - RAS only changes when its op is the selected one (suppressed by stall, exception, eret).
- Arithmetic: all PC sums modulo 2^PC_WIDTH; pc_out = all-ones increments to 0, no flag.
- Exceptions and eret do not touch the RAS.

## Timing
- Reset (rst=1 at edge): pc_out=RESET_VECTOR, epc_out=0, in_exc=0, RAS count=0 (ras_empty=1, ras_full=0), ras_err=0. Reset overrides every input; asserting mid-operation discards pending redirect and RAS contents.
- pc_out, epc_out, in_exc, ras_empty, ras_full: registered, update one edge after the inputs are sampled.
- pc_next: combinational from current inputs and state; equals pc_out after the next edge (if rst=0).
- ras_err: high for exactly the cycle after the offending edge.
- Redirect latency: one cycle; no internal bubbles.

## Test plan
- Reset then 70 cycles pc_write=1, no redirects → pc_out 0,1,…,63,0,… (wrap at 63→0); pc_next always pc_out+1.
- pc_out=5, pc_write=0 for 3 cycles with br_taken=1, br_target=20 → pc_out stays 5; pc_write=1 → 20.
- pc_out=10, exc_req=1 with pc_write=0 → pc_out=0x3C, epc_out=10, in_exc=1; second exc_req → ignored, pc_out=0x3D; eret → pc_out=10, in_exc=0.
- call at pc 2,8,14,20,26 (jump_target 8,14,20,26,30), RAS_DEPTH=4 → 5th call pulses ras_err, ras_full=1; 4 rets → 27,21,15,9; 5th ret → pc_out+1, ras_err pulse, ras_empty=1.
- Same cycle call=1, ret=1, br_taken=1 with RAS top=40 → pc_out=40, count decremented, no push.
- rst asserted while in_exc=1, RAS count=3 → next cycle pc_out=0, in_exc=0, epc_out=0, ras_empty=1.
